// File: rtl/ct_fadd_close_s2_h.sv
// Close-path stage 2 of the half-precision FADD: magnitude, normalize, one-bit fixup, subnormal clamp.
// Optional macro CT_FADD_CLOSE_S2_PERF_EN adds a saturating corr_cnt output.
module ct_fadd_close_s2_h #(
  parameter int FRAC_W = 12,
  parameter int EXP_W  = 5
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              pipe_flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [FRAC_W-1:0] close_sum,
  input  logic [FRAC_W-1:0] close_sum_m1,
  input  logic              close_op_chg,
  input  logic [5:0]        ff1_pred,
  input  logic              rnd_inc,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              sign_in,
  input  logic [2:0]        rm,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [FRAC_W-1:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              sign_out,
  output logic              zero_out,
  output logic              corr_out
`ifdef CT_FADD_CLOSE_S2_PERF_EN
  ,
  output logic [15:0]       corr_cnt
`endif
);

  // Handshake: a register accepts when empty or when its consumer takes its
  // entry in the same cycle; a transfer happens when valid and accept are both high.
  logic s2_vld, s3_vld;
  logic s3_acc, in_fire, s2_xfer;

  logic [FRAC_W-1:0] s2_mag;
  logic              s2_sign;
  logic [EXP_W-1:0]  s2_exp;
  logic [5:0]        s2_ff1;
  logic [2:0]        s2_rm;

  logic [FRAC_W-1:0] mag_in;

  logic [5:0]        lim;
  logic [5:0]        sh0;
  logic [5:0]        sh;
  logic [FRAC_W-1:0] t;
  logic [FRAC_W-1:0] frac_n;
  logic [EXP_W-1:0]  exp_n;
  logic              sign_n;
  logic              zero_n;
  logic              corr_n;

  assign s3_acc  = !s3_vld || out_rdy;
  assign in_rdy  = !s2_vld || s3_acc;
  assign in_fire = in_vld && in_rdy && !pipe_flush;
  assign s2_xfer = s2_vld && s3_acc && !pipe_flush;
  assign out_vld = s3_vld;

  assign mag_in = close_op_chg ? ('0 - close_sum) : (rnd_inc ? close_sum_m1 : close_sum);

  always_comb begin
    lim    = {1'b0, s2_exp - 5'd1};
    sh0    = (s2_ff1 < lim) ? s2_ff1 : lim;
    t      = s2_mag << sh0;
    sh     = sh0;
    corr_n = 1'b0;
    // The predictor may be one short; an extra shift is allowed only below the exponent limit.
    if (!t[FRAC_W-1] && t[FRAC_W-2] && (sh0 < lim)) begin
      sh     = sh0 + 6'd1;
      corr_n = 1'b1;
    end
    frac_n = s2_mag << sh;
    exp_n  = frac_n[FRAC_W-1] ? (s2_exp - sh[EXP_W-1:0]) : '0;
    sign_n = s2_sign;
    zero_n = 1'b0;
    if (s2_mag == '0) begin
      frac_n = '0;
      exp_n  = '0;
      sign_n = (s2_rm == 3'b010);
      zero_n = 1'b1;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else if (pipe_flush) begin
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else begin
      if (in_fire)      s2_vld <= 1'b1;
      else if (s2_xfer) s2_vld <= 1'b0;
      if (s3_acc)       s3_vld <= s2_vld;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      s2_mag  <= '0;
      s2_sign <= 1'b0;
      s2_exp  <= '0;
      s2_ff1  <= '0;
      s2_rm   <= '0;
    end else if (in_fire) begin
      s2_mag  <= mag_in;
      s2_sign <= sign_in ^ close_op_chg;
      s2_exp  <= exp_in;
      s2_ff1  <= ff1_pred;
      s2_rm   <= rm;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      frac_out <= '0;
      exp_out  <= '0;
      sign_out <= 1'b0;
      zero_out <= 1'b0;
      corr_out <= 1'b0;
    end else if (s2_xfer) begin
      frac_out <= frac_n;
      exp_out  <= exp_n;
      sign_out <= sign_n;
      zero_out <= zero_n;
      corr_out <= corr_n;
    end
  end

`ifdef CT_FADD_CLOSE_S2_PERF_EN
  // Survives flush so software sees lifetime misprediction totals.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      corr_cnt <= '0;
    end else if (s2_xfer && corr_n && (corr_cnt != 16'hFFFF)) begin
      corr_cnt <= corr_cnt + 16'd1;
    end
  end
`else
  // No misprediction counter in this build.
`endif

endmodule

// File: tb/tb_ct_fadd_close_s2_h.sv
// Bench for ct_fadd_close_s2_h: directed test-plan steps, randomized traffic with backpressure,
// and a negedge scoreboard fed by an arithmetic reference model.
module tb_ct_fadd_close_s2_h;

  logic        clk;
  logic        rst;
  logic        pipe_flush;
  logic        in_vld;
  logic        in_rdy;
  logic [11:0] close_sum;
  logic [11:0] close_sum_m1;
  logic        close_op_chg;
  logic [5:0]  ff1_pred;
  logic        rnd_inc;
  logic [4:0]  exp_in;
  logic        sign_in;
  logic [2:0]  rm;
  logic        out_vld;
  logic        out_rdy;
  logic [11:0] frac_out;
  logic [4:0]  exp_out;
  logic        sign_out;
  logic        zero_out;
  logic        corr_out;
`ifdef CT_FADD_CLOSE_S2_PERF_EN
  logic [15:0] corr_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [19:0] exp_q[$];

  ct_fadd_close_s2_h dut (
    .forever_cpuclk(clk),
    .cpurst(rst),
    .pipe_flush(pipe_flush),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .close_sum(close_sum),
    .close_sum_m1(close_sum_m1),
    .close_op_chg(close_op_chg),
    .ff1_pred(ff1_pred),
    .rnd_inc(rnd_inc),
    .exp_in(exp_in),
    .sign_in(sign_in),
    .rm(rm),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .frac_out(frac_out),
    .exp_out(exp_out),
    .sign_out(sign_out),
    .zero_out(zero_out),
    .corr_out(corr_out)
`ifdef CT_FADD_CLOSE_S2_PERF_EN
    ,
    .corr_cnt(corr_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference: result packed as {frac[11:0], exp[4:0], sign, zero, corr}.
  function automatic logic [19:0] model(input logic [11:0] sum, input logic [11:0] m1,
                                        input logic op, input logic inc, input logic [5:0] ff1,
                                        input logic [4:0] e, input logic s, input logic [2:0] r);
    int mag, lim, sh, frac, ex, corr;
    if (op) mag = (4096 - int'(sum)) % 4096;
    else    mag = inc ? int'(m1) : int'(sum);
    if (mag == 0) return {12'd0, 5'd0, (r == 3'b010), 1'b1, 1'b0};
    lim  = (int'(e) + 31) % 32;
    sh   = (int'(ff1) < lim) ? int'(ff1) : lim;
    corr = 0;
    frac = (mag << sh) % 4096;
    if ((frac / 1024) == 1 && sh < lim) begin
      sh   = sh + 1;
      corr = 1;
      frac = (mag << sh) % 4096;
    end
    ex = (frac >= 2048) ? (int'(e) - sh + 32) % 32 : 0;
    return {frac[11:0], ex[4:0], s ^ op, 1'b0, corr[0]};
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected observed=%h expected=none",
                 {frac_out, exp_out, sign_out, zero_out, corr_out});
        end else begin
          check("sb_result", {12'd0, frac_out, exp_out, sign_out, zero_out, corr_out},
                {12'd0, exp_q.pop_front()});
        end
      end
      if (pipe_flush) exp_q.delete();
      else if (in_vld && in_rdy)
        exp_q.push_back(model(close_sum, close_sum_m1, close_op_chg, rnd_inc, ff1_pred,
                              exp_in, sign_in, rm));
    end
  end

  task automatic drive(input logic [11:0] sum, input logic op, input logic inc,
                       input logic [5:0] ff1, input logic [4:0] e, input logic s,
                       input logic [2:0] r);
    close_sum    = sum;
    close_sum_m1 = sum + 12'd2;
    close_op_chg = op;
    rnd_inc      = inc;
    ff1_pred     = ff1;
    exp_in       = e;
    sign_in      = s;
    rm           = r;
  endtask

  // One transaction through an empty pipe, checking latency and result fields.
  task automatic directed(input string tag, input logic [11:0] sum, input logic op,
                          input logic [5:0] ff1, input logic [4:0] e, input logic s,
                          input logic [2:0] r, input logic [11:0] efrac, input logic [4:0] eexp,
                          input logic esign, input logic ezero, input logic ecorr);
    drive(sum, op, 1'b0, ff1, e, s, r);
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    check({tag, "_lat1"}, {31'd0, out_vld}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_vld"}, {31'd0, out_vld}, 32'd1);
    check({tag, "_res"}, {12'd0, frac_out, exp_out, sign_out, zero_out, corr_out},
          {12'd0, efrac, eexp, esign, ezero, ecorr});
    @(posedge clk); #1;
  endtask

  task automatic send_rand(input logic bp);
    logic [11:0] mag;
    logic [11:0] tmp;
    int lz, n;
    logic acc;
    mag = 12'($urandom_range(0, 4095) >> $urandom_range(0, 12));
    lz = 0;
    tmp = mag;
    while (lz < 11 && !tmp[11]) begin
      tmp = tmp << 1;
      lz++;
    end
    if ($urandom_range(0, 1) == 1 && mag != 12'd0 && mag <= 12'd2048)
      drive(12'd0 - mag, 1'b1, 1'b0, 6'(lz), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 4)));
    else
      drive(mag & 12'h7FF, 1'b0, 1'($urandom_range(0, 1)), 6'(lz), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)));
    if ($urandom_range(0, 2) == 0 && ff1_pred != 6'd0) ff1_pred = ff1_pred - 6'd1;
    in_vld = 1'b1;
    n = 0;
    do begin
      if (bp) out_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=in_rdy_low expected=accept_within_200");
    end
    in_vld = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      if (bp) out_rdy = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    pipe_flush = 1'b0;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    drive(12'd0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vld", {31'd0, out_vld}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("rst_outputs", {12'd0, frac_out, exp_out, sign_out, zero_out, corr_out}, 32'd0);
    @(posedge clk); #1;

    directed("exact",    12'h0C0, 1'b0, 6'd4, 5'd15, 1'b0, 3'b000, 12'hC00, 5'd11, 1'b0, 1'b0, 1'b0);
    directed("underpred", 12'h0C0, 1'b0, 6'd3, 5'd15, 1'b0, 3'b000, 12'hC00, 5'd11, 1'b0, 1'b0, 1'b1);
    directed("negdiff",  12'hFF0, 1'b1, 6'd7, 5'd15, 1'b0, 3'b000, 12'h800, 5'd8,  1'b1, 1'b0, 1'b0);
    directed("subnorm",  12'h0C0, 1'b0, 6'd4, 5'd3,  1'b0, 3'b000, 12'h300, 5'd0,  1'b0, 1'b0, 1'b0);
    directed("zero_rdn", 12'h000, 1'b0, 6'd0, 5'd15, 1'b0, 3'b010, 12'h000, 5'd0,  1'b1, 1'b1, 1'b0);
    directed("zero_rne", 12'h000, 1'b0, 6'd0, 5'd15, 1'b0, 3'b000, 12'h000, 5'd0,  1'b0, 1'b1, 1'b0);

    // Backpressure with three back-to-back inputs, then flush.
    out_rdy = 1'b0;
    drive(12'h0C0, 1'b0, 1'b0, 6'd4, 5'd15, 1'b0, 3'b000);
    in_vld = 1'b1;
    @(posedge clk); #1;
    drive(12'h030, 1'b0, 1'b0, 6'd6, 5'd20, 1'b1, 3'b000);
    @(posedge clk); #1;
    drive(12'h001, 1'b0, 1'b0, 6'd11, 5'd20, 1'b0, 3'b000);
    check("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
    check("bp_out_vld", {31'd0, out_vld}, 32'd1);
    check("bp_head", {12'd0, frac_out, exp_out, sign_out, zero_out, corr_out},
          {12'd0, 12'hC00, 5'd11, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("bp_hold", {12'd0, frac_out, exp_out, sign_out, zero_out, corr_out},
          {12'd0, 12'hC00, 5'd11, 1'b0, 1'b0, 1'b0});
    check("bp_in_rdy2", {31'd0, in_rdy}, 32'd0);
    pipe_flush = 1'b1;
    @(posedge clk); #1;
    pipe_flush = 1'b0;
    in_vld = 1'b0;
    check("flush_out_vld", {31'd0, out_vld}, 32'd0);
    check("flush_in_rdy", {31'd0, in_rdy}, 32'd1);
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_stays_empty", {31'd0, out_vld}, 32'd0);

    // Randomized traffic: free-flowing, then with random backpressure.
    for (int i = 0; i < 150; i++) send_rand(1'b0);
    for (int i = 0; i < 250; i++) send_rand(1'b1);

    out_rdy = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_vld) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
